// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of X - Y - Bin.
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per cycle, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .X    (a_q[0]),
        .Y    (b_q[0]),
        .Bin  (br_q),
        .Diff (fs_diff),
        .Bout (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bout;
                res_d = {fs_diff, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // The last bit lands in the result register and the outputs on the same edge.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs_diff, res_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The port list SHALL be exactly as follows, clock and reset first:
- Clk  input  1  sole clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request to begin a subtraction.
- A  input  WIDTH  minuend; sampled only when Start is accepted.
- B  input  WIDTH  subtrahend; sampled only when Start is accepted.
- Bin  input  1  borrow-in; sampled only when Start is accepted.
- Busy  output  1  high while a subtraction is in progress.
- Done  output  1  one-cycle pulse when a result is valid.
- Diff  output  WIDTH  result A-B-Bin, modulo 2^WIDTH.
- Bout  output  1  final borrow-out; 1 iff A < B+Bin, unsigned.
REQ-003 Clocking and reset SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 Start SHALL be accepted when the state is IDLE or DONE; acceptance SHALL:
- latch A, B and Bin;
- clear the bit counter;
- load the borrow register with Bin;
- move to RUN.
REQ-006 Start SHALL be ignored in RUN, with no effect on state, counter or latched operands.
REQ-007 In RUN, each cycle SHALL process one bit, LSB first:
- d = a ^ b ^ br;
- br_next = (~a & b) | (~(a ^ b) & br);
- both operand registers shift right by one;
- d shifts into the MSB of an internal result register.
REQ-008 RUN SHALL last exactly WIDTH cycles, then the FSM SHALL go to DONE.
REQ-009 On the RUN-to-DONE transition, Diff and Bout SHALL load from the internal result register and final borrow.
REQ-010 Busy SHALL be high exactly while in RUN.
REQ-011 Done SHALL be high exactly while in DONE, which lasts one cycle.
REQ-012 DONE SHALL go to IDLE, or to RUN if Start is high in that cycle.
REQ-013 Latency: with Start accepted at edge 0, Busy SHALL be high after edges 1..WIDTH and Done SHALL be high after edge WIDTH+1.
REQ-014 Diff and Bout SHALL hold their last values through IDLE and through any subsequent RUN until the next DONE load.
REQ-015 Changes on A, B or Bin after acceptance SHALL NOT affect the result in progress.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a run.
REQ-017 Results SHALL match the boundary cases:
- A=B, Bin=0 gives Diff=0, Bout=0.
- A=0, B=2^WIDTH-1, Bin=1 gives Diff=0, Bout=1.

Reset
REQ-018 While Rst is high at a clock edge, the block SHALL go to IDLE and clear counter, borrow, operand and result registers, with Busy=0, Done=0, Diff=0, Bout=0.
REQ-019 Rst SHALL take priority over Start in the same cycle.
REQ-020 Rst asserted during RUN SHALL abort the operation: no Done pulse, outputs zero.
REQ-021 Start SHALL be accepted in the first cycle after Rst deasserts.

Structure
REQ-022 The shared package serial_subtractor_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the constant DEFAULT_WIDTH = 8.
REQ-023 The per-bit logic SHALL be a combinational sub-module full_subtractor with:
- inputs X, Y, Bin;
- outputs Diff = X^Y^Bin;
- output Bout = (~X&Y) | (~(X^Y)&Bin).
REQ-024 The top level SHALL instantiate full_subtractor exactly once, together with the FSM, shift registers, counter and borrow flop.

Verification (WIDTH=8)
REQ-025 Start with A=100, B=37, Bin=0 -> Done pulse 9 cycles after acceptance, Diff=0x3F (63), Bout=0, Busy high for 8 cycles.
REQ-026 A=5, B=10, Bin=0 -> Diff=0xFB, Bout=1; then A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1.
REQ-027 Start with A=0x80, B=0x01 held high throughout RUN, A/B changed mid-run -> Diff=0x7F, Bout=0, exactly one Done pulse; ignored Starts cause no restart.
REQ-028 Rst pulsed on the 4th RUN cycle -> Busy=0, Done never pulses, Diff=0, Bout=0; a Start on the next cycle completes normally.
REQ-029 Start asserted in the DONE cycle with A=0xFF, B=0x0F -> Busy high on the next cycle, Done pulses 9 cycles later with Diff=0xF0, Bout=0.
REQ-030 Start asserted in the DONE cycle -> the previous result is held on Diff/Bout until the new DONE.
